frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
Frame-level controller that sequences the pixel array and the shared column ADC through one capture: frame reset, programmable exposure, then per-row ADC reset, conversion and readout. It sits above the per-pixel state logic and the ADC. It generates the frame_reset, expose_enable, adc_reset, convert and read strobes, plus row selection. It supports single-shot and continuous capture, and has an ADC timeout guard.

Parameters:
ROWS, 4, number of pixel rows read per frame (>=1)
ROW_W, 2, width of row_sel (ceil(log2(ROWS)), min 1)
EXP_W, 8, width of exposure cycle count
RESET_CYCLES, 2, frame_reset assertion length in clocks (>=1)
ADC_TIMEOUT, 255, max clocks in CONVERT waiting for adc_finished (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
state_reset_n  input  1  synchronous active-low reset
start  input  1  request one capture; sampled only in IDLE
continuous  input  1  sampled in DONE: 1 = restart at FRAME_RESET, 0 = return to IDLE
expose_cycles  input  EXP_W  exposure length in clocks; latched when start accepted
adc_finished  input  1  ADC conversion complete; honoured only in CONVERT
frame_reset  output  1  pixel array reset strobe
expose_enable  output  1  exposure window
adc_reset  output  1  ADC reset strobe
convert  output  1  ADC conversion request
read  output  1  row readout strobe
row_sel  output  ROW_W  current row index
busy  output  1  high whenever state != IDLE
frame_done  output  1  one-clock pulse at frame completion
adc_timeout  output  1  sticky error flag

Behaviour:
- One clock (clk). Reset is synchronous and active-low (state_reset_n).
- All outputs are registered and decoded from the state register; there are no combinational paths from inputs to outputs.
- Reset (state_reset_n=0 at a rising edge):
  - state=IDLE.
  - All outputs = 0, including row_sel and adc_timeout.
  - All counters = 0.
  - Reset has priority over everything, mid-frame included. Strobes drop the cycle after the reset edge.
- States: IDLE, FRAME_RESET, EXPOSE, ADC_RESET, CONVERT, READ, DONE.
- IDLE:
  - If start=1: latch exp_len = max(expose_cycles, 1), clear adc_timeout, go to FRAME_RESET.
  - start is ignored in every other state.
- FRAME_RESET:
  - frame_reset=1 for exactly RESET_CYCLES clocks, then EXPOSE.
  - row_sel=0.
- EXPOSE:
  - expose_enable=1 for exactly exp_len clocks; expose_cycles=0 behaves as 1.
  - Then ADC_RESET.
- ADC_RESET: adc_reset=1 for exactly 1 clock, then CONVERT.
- CONVERT:
  - convert=1 and a timeout counter runs from 0.
  - adc_finished=1 sampled -> READ on the next edge; convert drops in that same cycle.
  - If the counter reaches ADC_TIMEOUT without adc_finished: set adc_timeout=1, go to IDLE (frame aborted, no frame_done).
  - If adc_finished and the timeout coincide on the same edge, adc_finished wins.
- READ:
  - read=1 for exactly 1 clock, with row_sel holding the current row.
  - If row == ROWS-1 -> DONE. Otherwise row_sel increments and the FSM goes to ADC_RESET.
  - row_sel never wraps within a frame.
- DONE:
  - frame_done=1 for 1 clock; row_sel returns to 0.
  - continuous=1 -> FRAME_RESET, reusing the latched exp_len. Otherwise -> IDLE.
- Mutual exclusion: at most one of frame_reset, expose_enable, adc_reset, convert, read is high in any cycle.
- adc_finished outside CONVERT is ignored and does not pre-arm the next conversion.
- Latency, start edge to first frame_reset high: 1 clock.
- Frame length with an ADC responding after k convert cycles (k = number of clocks convert is high):
  - 1 + RESET_CYCLES + exp_len + ROWS*(1 + k + 1) + 1 clocks from the start edge to the frame_done cycle inclusive.
- busy is high from the cycle after start is accepted through the DONE cycle.

Test Plan:
1. Single shot, defaults, expose_cycles=10, adc_finished driven high on the 3rd convert cycle -> frame_reset high 2 clocks, expose_enable high 10 clocks, four adc_reset/convert(3)/read groups with row_sel=0,1,2,3, one frame_done pulse, return to IDLE with busy=0; one-hot strobe check every cycle.
2. expose_cycles=0, then expose_cycles changed mid-frame from 5 to 20 -> exposure lasts 1 clock in the first frame and 5 clocks in the second (latched value used).
3. adc_finished never asserted -> convert high exactly 255 clocks, adc_timeout=1, state IDLE, no frame_done; next start clears adc_timeout.
4. continuous=1 held for two frames -> DONE is followed immediately by frame_reset with no IDLE cycle; frame_done pulses twice.
5. state_reset_n driven low during CONVERT of row 2 -> next cycle all outputs 0, row_sel=0, busy=0; start while busy and adc_finished outside CONVERT both ignored.
6. adc_finished asserted on the exact timeout cycle -> READ entered, adc_timeout stays 0.

Source files
------------

// File: rtl/frame_sequencer.sv
// Frame-level capture sequencer: frame reset, exposure, then per-row
// ADC reset / convert / read, with single-shot, continuous and ADC timeout.
module frame_sequencer #(
    parameter int ROWS         = 4,
    parameter int ROW_W        = 2,
    parameter int EXP_W        = 8,
    parameter int RESET_CYCLES = 2,
    parameter int ADC_TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             state_reset_n,
    input  logic             start,
    input  logic             continuous,
    input  logic [EXP_W-1:0] expose_cycles,
    input  logic             adc_finished,
    output logic             frame_reset,
    output logic             expose_enable,
    output logic             adc_reset,
    output logic             convert,
    output logic             read,
    output logic [ROW_W-1:0] row_sel,
    output logic             busy,
    output logic             frame_done,
    output logic             adc_timeout
);

    localparam int TMO_W = $clog2(ADC_TIMEOUT + 1);
    localparam int RST_W = $clog2(RESET_CYCLES + 1);
    localparam int CW1   = (EXP_W > TMO_W) ? EXP_W : TMO_W;
    localparam int CNT_W = (CW1 > RST_W) ? CW1 : RST_W;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ADC_TIMEOUT - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRAME_RESET,
        S_EXPOSE,
        S_ADC_RESET,
        S_CONVERT,
        S_READ,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [EXP_W-1:0]   exp_len_q, exp_len_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   exp_last;

    logic frame_reset_q, expose_enable_q, adc_reset_q;
    logic convert_q, read_q, busy_q, frame_done_q;

    // exp_len is never zero, so the subtraction cannot underflow
    assign exp_last = CNT_W'(exp_len_q) - CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        exp_len_d = exp_len_q;
        timeout_d = timeout_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    exp_len_d = (expose_cycles == '0) ?
                                EXP_W'(1) : expose_cycles;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    row_d     = '0;
                    state_d   = S_FRAME_RESET;
                end
            end
            S_FRAME_RESET: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = S_EXPOSE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXPOSE: begin
                if (cnt_q == exp_last) begin
                    cnt_d   = '0;
                    state_d = S_ADC_RESET;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ADC_RESET: begin
                cnt_d   = '0;
                state_d = S_CONVERT;
            end
            S_CONVERT: begin
                // a finish on the timeout cycle still completes the row
                if (adc_finished) begin
                    cnt_d   = '0;
                    state_d = S_READ;
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d     = '0;
                    row_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_READ: begin
                if (row_q == ROW_LAST) begin
                    row_d   = '0;
                    state_d = S_DONE;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = S_ADC_RESET;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = continuous ? S_FRAME_RESET : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!state_reset_n) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            row_q           <= '0;
            exp_len_q       <= '0;
            timeout_q       <= 1'b0;
            frame_reset_q   <= 1'b0;
            expose_enable_q <= 1'b0;
            adc_reset_q     <= 1'b0;
            convert_q       <= 1'b0;
            read_q          <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            row_q           <= row_d;
            exp_len_q       <= exp_len_d;
            timeout_q       <= timeout_d;
            frame_reset_q   <= (state_d == S_FRAME_RESET);
            expose_enable_q <= (state_d == S_EXPOSE);
            adc_reset_q     <= (state_d == S_ADC_RESET);
            convert_q       <= (state_d == S_CONVERT);
            read_q          <= (state_d == S_READ);
            busy_q          <= (state_d != S_IDLE);
            frame_done_q    <= (state_d == S_DONE);
        end
    end

    assign frame_reset   = frame_reset_q;
    assign expose_enable = expose_enable_q;
    assign adc_reset     = adc_reset_q;
    assign convert       = convert_q;
    assign read          = read_q;
    assign row_sel       = row_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign adc_timeout   = timeout_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: a cycle-level plan of the capture
// is built from the frame rules and checked every clock by a monitor.
module tb_frame_sequencer;

    logic       clk;
    logic       state_reset_n;
    logic       start;
    logic       continuous;
    logic [7:0] expose_cycles;
    logic       adc_finished;
    logic       frame_reset;
    logic       expose_enable;
    logic       adc_reset;
    logic       convert;
    logic       read;
    logic [1:0] row_sel;
    logic       busy;
    logic       frame_done;
    logic       adc_timeout;

    frame_sequencer #(
        .ROWS(4), .ROW_W(2), .EXP_W(8),
        .RESET_CYCLES(2), .ADC_TIMEOUT(255)
    ) dut (
        .clk(clk),
        .state_reset_n(state_reset_n),
        .start(start),
        .continuous(continuous),
        .expose_cycles(expose_cycles),
        .adc_finished(adc_finished),
        .frame_reset(frame_reset),
        .expose_enable(expose_enable),
        .adc_reset(adc_reset),
        .convert(convert),
        .read(read),
        .row_sel(row_sel),
        .busy(busy),
        .frame_done(frame_done),
        .adc_timeout(adc_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       fr;
        logic       ex;
        logic       ar;
        logic       cv;
        logic       rd;
        logic [1:0] row;
        logic       busy;
        logic       done;
        logic       to;
    } outv_t;

    outv_t exp_q[$];
    int    checks = 0;
    int    fails  = 0;
    int    m_len  = 1;
    logic  m_to   = 1'b0;

    // kind: 0 idle, 1 frame reset, 2 expose, 3 adc reset,
    // 4 convert, 5 read, 6 done
    function automatic outv_t mk(input int kind, input int row,
                                 input logic to);
        outv_t o;
        o      = '0;
        o.to   = to;
        o.busy = (kind != 0);
        o.fr   = (kind == 1);
        o.ex   = (kind == 2);
        o.ar   = (kind == 3);
        o.cv   = (kind == 4);
        o.rd   = (kind == 5);
        o.done = (kind == 6);
        if (kind >= 3 && kind <= 5) o.row = 2'(row);
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cyc(input logic st, input logic [7:0] e,
                       input logic co, input logic fi,
                       input logic rn, input outv_t o);
        @(posedge clk);
        #1;
        exp_q.push_back(o);
        start         = st;
        expose_cycles = e;
        continuous    = co;
        adc_finished  = fi;
        state_reset_n = rn;
    endtask

    // busy cycle with every ignorable input randomised
    task automatic bc(input outv_t o);
        cyc(rb(), 8'($urandom), rb(), rb(), 1'b1, o);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'($urandom), rb(), rb(), 1'b1,
                       mk(0, 0, m_to));
    endtask

    // mode: 0 normal, 1 timeout at srow, 2 reset in convert of srow,
    // 3 finish on the last allowed convert cycle of srow
    task automatic run(input int e, input int nf, input int kfix,
                       input int mode, input int srow);
        int k;
        cyc(1'b1, 8'(e), rb(), rb(), 1'b1, mk(0, 0, m_to));
        m_len = (e == 0) ? 1 : e;
        m_to  = 1'b0;
        for (int f = 0; f < nf; f++) begin
            repeat (2) bc(mk(1, 0, 1'b0));
            repeat (m_len) bc(mk(2, 0, 1'b0));
            for (int r = 0; r < 4; r++) begin
                bc(mk(3, r, 1'b0));
                if (mode == 1 && r == srow) begin
                    repeat (255) cyc(rb(), 8'($urandom), rb(), 1'b0,
                                     1'b1, mk(4, r, 1'b0));
                    m_to = 1'b1;
                    return;
                end
                if (mode == 2 && r == srow) begin
                    cyc(rb(), 8'($urandom), rb(), 1'b0, 1'b1,
                        mk(4, r, 1'b0));
                    cyc(rb(), 8'($urandom), rb(), rb(), 1'b0,
                        mk(4, r, 1'b0));
                    m_to = 1'b0;
                    return;
                end
                if (mode == 3 && r == srow) k = 255;
                else if (kfix > 0) k = kfix;
                else k = $urandom_range(1, 6);
                for (int j = 1; j <= k; j++)
                    cyc(rb(), 8'($urandom), rb(), 1'(j == k), 1'b1,
                        mk(4, r, 1'b0));
                bc(mk(5, r, 1'b0));
            end
            cyc(rb(), 8'($urandom), 1'(f < nf - 1), rb(), 1'b1,
                mk(6, 0, 1'b0));
        end
    endtask

    outv_t got;
    outv_t want;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            got  = {frame_reset, expose_enable, adc_reset, convert, read,
                    row_sel, busy, frame_done, adc_timeout};
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL outputs t=%0t got=%b required=%b",
                         $time, got, want);
            end
            checks++;
            if ($countones({frame_reset, expose_enable, adc_reset,
                            convert, read}) > 1) begin
                fails++;
                $display("FAIL onehot t=%0t strobes=%b required<=1 high",
                         $time, {frame_reset, expose_enable, adc_reset,
                                 convert, read});
            end
        end
    end

    initial begin
        state_reset_n = 1'b0;
        start         = 1'b0;
        continuous    = 1'b0;
        expose_cycles = '0;
        adc_finished  = 1'b0;
        repeat (2) @(posedge clk);
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, mk(0, 0, 1'b0));
        idle(3);
        run(10, 1, 3, 0, 0);
        idle(3);
        run(0, 1, 0, 0, 0);
        idle(2);
        run(5, 1, 0, 0, 0);
        idle(2);
        run(8, 1, 0, 1, 1);
        idle(4);
        run(2, 1, 0, 0, 0);
        idle(2);
        run(3, 2, 0, 0, 0);
        idle(2);
        run(4, 1, 0, 2, 2);
        idle(3);
        run(2, 1, 0, 3, 0);
        idle(2);
        for (int i = 0; i < 6; i++) begin
            run($urandom_range(0, 12), $urandom_range(1, 2), 0, 0, 0);
            idle($urandom_range(1, 3));
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
